// File: rtl/sh_mac_unit.sv
// sh_mac_unit: SH CPU multiply/accumulate unit (MUL.L, DMULx.L, MULx.W, MAC.W, MAC.L, CLRMAC, LDS/STS)
//   Ports: CLK, RST_N (async, active-low), CE_R/CE_F clock enables, RES_N soft reset (qualified by CE_R),
//   CBUS_A/CBUS_DI/CBUS_DO/CBUS_WR/CBUS_BA/CBUS_REQ/CBUS_BUSY internal bus,
//   MAC_SEL/MAC_OP/MAC_S/MAC_WE control from the decoder.
//   Optional feature macro: SH_MAC_SAT_EN (MAC_S-controlled saturation of MAC.W / MAC.L).
module sh_mac_unit #(
  parameter int MACH_W     = 32,
  parameter int MUL_CYCLES = 2
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        CE_R,
  input  logic        CE_F,
  input  logic        RES_N,
  input  logic [27:0] CBUS_A,
  input  logic [31:0] CBUS_DI,
  output logic [31:0] CBUS_DO,
  input  logic        CBUS_WR,
  input  logic [3:0]  CBUS_BA,
  input  logic        CBUS_REQ,
  output logic        CBUS_BUSY,
  input  logic [1:0]  MAC_SEL,
  input  logic [3:0]  MAC_OP,
  input  logic        MAC_S,
  input  logic        MAC_WE
);
  localparam int AW = 32 + MACH_W;
  typedef enum logic {IDLE, EXEC} state_t;
  state_t            state_q, state_d;
  logic [MACH_W-1:0] mach_q, mach_d;
  logic [31:0]       macl_q, macl_d, a_q, a_d, b_q, b_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [3:0]        op_q, op_d;
  logic              s_q, s_d, sgn_q, sgn_d;
  logic              wr_ok, is_mul, mul_w, mac_w;
  logic [15:0]       mac_h;
  logic [31:0]       wa, wb;
  logic [63:0]       ax, bx, p;
  logic [AW-1:0]     acc;
  logic              unused_ok;
  assign unused_ok = ^{CE_F, CBUS_WR, CBUS_BA, CBUS_A[27:2], CBUS_A[0]};
  assign wr_ok  = MAC_WE & |MAC_SEL & CE_R & (state_q == IDLE);
  assign is_mul = MAC_OP inside {4'b0001, 4'b0010, 4'b0011, 4'b1001, 4'b0110, 4'b0111, 4'b1011};
  assign mul_w  = MAC_OP inside {4'b0110, 4'b0111};
  assign mac_w  = MAC_OP == 4'b1011;
  // MAC.W picks one halfword of the bus word by address bit 1
  assign mac_h  = CBUS_A[1] ? CBUS_DI[15:0] : CBUS_DI[31:16];
  assign wa = mac_w ? 32'(signed'(mac_h)) :
              mul_w ? (MAC_OP[0] ? 32'(signed'(CBUS_DI[15:0])) : {16'b0, CBUS_DI[15:0]}) : CBUS_DI;
  assign wb = mac_w ? 32'(signed'(mac_h)) :
              mul_w ? (MAC_OP[0] ? 32'(signed'(CBUS_DI[31:16])) : {16'b0, CBUS_DI[31:16]}) : CBUS_DI;
  // Low 64 bits of the product of the extended operands are exact for both signednesses
  assign ax  = sgn_q ? {{32{a_q[31]}}, a_q} : {32'b0, a_q};
  assign bx  = sgn_q ? {{32{b_q[31]}}, b_q} : {32'b0, b_q};
  assign p   = ax * bx;
  assign acc = {mach_q, macl_q} + p[AW-1:0];
`ifdef SH_MAC_SAT_EN
  localparam logic [64:0] LMAX = 65'h0_00007FFF_FFFFFFFF;
  localparam logic [64:0] LMIN = 65'h1_FFFF8000_00000000;
  logic [32:0] w_sum;
  logic [64:0] l_sum, l_sat;
  logic        w_ovf;
  assign w_sum = {macl_q[31], macl_q} + {p[31], p[31:0]};
  assign w_ovf = w_sum[32] ^ w_sum[31];
  assign l_sum = 65'(signed'({mach_q, macl_q})) + {p[63], p};
  assign l_sat = $signed(l_sum) > $signed(LMAX) ? LMAX : $signed(l_sum) < $signed(LMIN) ? LMIN : l_sum;
`endif
  always_comb begin
    state_d = state_q;
    mach_d  = mach_q;
    macl_d  = macl_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    s_d     = s_q;
    sgn_d   = sgn_q;
    if (CE_R && !RES_N) begin
      state_d = IDLE;
      mach_d  = '0;
      macl_d  = '0;
      a_d     = '0;
      b_d     = '0;
      cnt_d   = '0;
      op_d    = '0;
      s_d     = 1'b0;
      sgn_d   = 1'b0;
    end else if (wr_ok) begin
      macl_d = MAC_OP == 4'b0100 ? CBUS_DI : MAC_OP == 4'b1111 ? '0 : macl_q;
      mach_d = MAC_OP == 4'b1000 ? CBUS_DI[MACH_W-1:0] : MAC_OP == 4'b1111 ? '0 : mach_q;
      a_d    = is_mul && MAC_SEL[0] ? wa : a_q;
      if (is_mul && MAC_SEL[1]) begin
        b_d     = wb;
        state_d = EXEC;
        cnt_d   = 3'(MUL_CYCLES - 1);
        op_d    = MAC_OP;
        s_d     = MAC_S;
        sgn_d   = MAC_OP[0];
      end
    end else if (state_q == EXEC && CE_R) begin
      cnt_d = cnt_q - 3'd1;
      if (cnt_q == '0) begin
        state_d = IDLE;
        cnt_d   = '0;
        macl_d  = p[31:0];
        if (op_q inside {4'b0010, 4'b0011})
          mach_d = p[AW-1:32];
        if (op_q inside {4'b1001, 4'b1011})
          {mach_d, macl_d} = acc;
`ifdef SH_MAC_SAT_EN
        if (s_q && op_q == 4'b1011) begin
          macl_d = w_ovf ? (w_sum[32] ? 32'h8000_0000 : 32'h7FFF_FFFF) : w_sum[31:0];
          mach_d = w_ovf ? (mach_q | MACH_W'(1)) : mach_q;
        end
        if (s_q && op_q == 4'b1001)
          {mach_d, macl_d} = l_sat[AW-1:0];
`endif
      end
    end
  end
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      mach_q  <= '0;
      macl_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
      s_q     <= 1'b0;
      sgn_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mach_q  <= mach_d;
      macl_q  <= macl_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      s_q     <= s_d;
      sgn_q   <= sgn_d;
    end
  end
  assign CBUS_DO   = MAC_SEL[1] ? 32'(signed'(mach_q)) : macl_q;
  assign CBUS_BUSY = (state_q != IDLE) & (CBUS_REQ | (MAC_WE & |MAC_SEL));
endmodule
